// File: rtl/mc_control_unit_pkg.sv
// Shared definitions for the RV32I multicycle control unit: FSM states,
// opcode constants, and the select/operation codes that the controller
// drives into the datapath.
package riscv_mc_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    EXECI    = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9,
    JAL      = 4'd10,
    JALR     = 4'd11,
    LUI      = 4'd12
  } state_t;

  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;
  localparam logic [2:0] ALU_SLL = 3'b110;
  localparam logic [2:0] ALU_SRL = 3'b111;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;
  localparam logic [1:0] RES_IMM       = 2'b11;

  // Immediate format from opcode; unsupported opcodes fall back to I.
  function automatic logic [2:0] imm_sel(input logic [6:0] op);
    case (op)
      OP_LW, OP_JALR, OP_I: imm_sel = IMM_I;
      OP_SW:                imm_sel = IMM_S;
      OP_BR:                imm_sel = IMM_B;
      OP_JAL:               imm_sel = IMM_J;
      OP_LUI, OP_AUIPC:     imm_sel = IMM_U;
      default:              imm_sel = IMM_I;
    endcase
  endfunction

  function automatic logic op_supported(input logic [6:0] op);
    case (op)
      OP_LW, OP_SW, OP_R, OP_I, OP_BR,
      OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: op_supported = 1'b1;
      default:                           op_supported = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mc_control_unit_alu_decoder.sv
// ALU operation decode for register-register and register-immediate ops.
//   is_r        in  1  instruction is R-type (enables sub via funct7_5)
//   funct3      in  3  Instr[14:12]
//   funct7_5    in  1  Instr[30]
//   alu_control out 3  ALU operation code
module alu_decoder
  import riscv_mc_pkg::*;
(
  input  logic       is_r,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  output logic [2:0] alu_control
);

  always_comb begin
    alu_control = ALU_ADD;
    case (funct3)
      3'b000:  alu_control = (is_r && funct7_5) ? ALU_SUB : ALU_ADD;
      3'b111:  alu_control = ALU_AND;
      3'b110:  alu_control = ALU_OR;
      3'b100:  alu_control = ALU_XOR;
      3'b010:  alu_control = ALU_SLT;
      3'b001:  alu_control = ALU_SLL;
      // Both right-shift forms map to the logical shift.
      3'b101:  alu_control = ALU_SRL;
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_control_unit.sv
// Multicycle sequencer for the RV32I datapath with a shared instruction/data
// memory. A Moore FSM walks each instruction through fetch, decode, execute,
// memory and writeback, driving the datapath enables and mux selects.
//   clk, rst      clock, asynchronous active-high reset
//   op, funct3, funct7_5, zero   instruction fields from IR and ALU zero flag
//   pc_write, ir_write, mem_write, reg_write   write enables
//   adr_src, result_src, alu_srcA, alu_srcB    datapath mux selects
//   alu_control, imm_src                       ALU op and immediate format
//   retire        last cycle of every instruction
//   illegal       unsupported opcode seen in DECODE
module mc_control_unit
  import riscv_mc_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  input  logic       zero,
  output logic       pc_write,
  output logic       ir_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       reg_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_srcA,
  output logic [1:0] alu_srcB,
  output logic [2:0] alu_control,
  output logic [2:0] imm_src,
  output logic       retire,
  output logic       illegal
);

  state_t     state, next_state;
  logic [2:0] alu_dec;
  logic       pc_write_c, ir_write_c, mem_write_c, reg_write_c, illegal_c;

  alu_decoder u_alu_decoder (
    .is_r       (op == OP_R),
    .funct3     (funct3),
    .funct7_5   (funct7_5),
    .alu_control(alu_dec)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= FETCH;
    else     state <= next_state;
  end

  always_comb begin
    next_state = FETCH;
    case (state)
      FETCH:  next_state = DECODE;
      DECODE: begin
        case (op)
          OP_LW, OP_SW: next_state = MEMADR;
          OP_R:         next_state = EXECR;
          OP_I:         next_state = EXECI;
          OP_BR:        next_state = BRANCH;
          OP_JAL:       next_state = JAL;
          OP_JALR:      next_state = JALR;
          OP_LUI:       next_state = LUI;
          OP_AUIPC:     next_state = ALUWB;
          default:      next_state = FETCH;
        endcase
      end
      MEMADR:   next_state = (op == OP_LW) ? MEMREAD : MEMWRITE;
      MEMREAD:  next_state = MEMWB;
      EXECR:    next_state = ALUWB;
      EXECI:    next_state = ALUWB;
      JAL:      next_state = ALUWB;
      JALR:     next_state = JAL;
      default:  next_state = FETCH;
    endcase
  end

  always_comb begin
    pc_write_c  = 1'b0;
    ir_write_c  = 1'b0;
    mem_write_c = 1'b0;
    reg_write_c = 1'b0;
    illegal_c   = 1'b0;
    adr_src     = 1'b0;
    result_src  = RES_ALUOUT;
    alu_srcA    = SRCA_PC;
    alu_srcB    = SRCB_RS2;
    alu_control = ALU_ADD;
    case (state)
      FETCH: begin
        ir_write_c = 1'b1;
        pc_write_c = 1'b1;
        alu_srcB   = SRCB_FOUR;
        result_src = RES_ALURESULT;
      end
      DECODE: begin
        alu_srcA  = SRCA_OLDPC;
        alu_srcB  = SRCB_IMM;
        illegal_c = !op_supported(op);
      end
      MEMADR: begin
        alu_srcA = SRCA_RS1;
        alu_srcB = SRCB_IMM;
      end
      MEMREAD: adr_src = 1'b1;
      MEMWB: begin
        result_src  = RES_DATA;
        reg_write_c = 1'b1;
      end
      MEMWRITE: begin
        adr_src     = 1'b1;
        mem_write_c = 1'b1;
      end
      EXECR: begin
        alu_srcA    = SRCA_RS1;
        alu_srcB    = SRCB_RS2;
        alu_control = alu_dec;
      end
      EXECI: begin
        alu_srcA    = SRCA_RS1;
        alu_srcB    = SRCB_IMM;
        alu_control = alu_dec;
      end
      ALUWB: reg_write_c = 1'b1;
      BRANCH: begin
        alu_srcA    = SRCA_RS1;
        alu_srcB    = SRCB_RS2;
        alu_control = ALU_SUB;
        pc_write_c  = ((funct3 == 3'b000) && zero) || ((funct3 == 3'b001) && !zero);
      end
      // PC loads the target held in ALUOut while the ALU forms OldPC+4
      // for the link writeback that follows in ALUWB.
      JAL: begin
        alu_srcA   = SRCA_OLDPC;
        alu_srcB   = SRCB_FOUR;
        pc_write_c = 1'b1;
      end
      JALR: begin
        alu_srcA = SRCA_RS1;
        alu_srcB = SRCB_IMM;
      end
      LUI: begin
        result_src  = RES_IMM;
        reg_write_c = 1'b1;
      end
      default: ;
    endcase
  end

  assign imm_src = imm_sel(op);

  // Reset suppresses every side effect immediately, independent of the clock.
  assign pc_write  = pc_write_c  && !rst;
  assign ir_write  = ir_write_c  && !rst;
  assign mem_write = mem_write_c && !rst;
  assign reg_write = reg_write_c && !rst;
  assign illegal   = illegal_c   && !rst;
  assign retire    = (state != FETCH) && (next_state == FETCH) && !rst;

endmodule

// File: tb/tb_mc_control_unit.sv
module tb_mc_control_unit;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] op = '0;
  logic [2:0] funct3 = '0;
  logic       funct7_5 = 1'b0;
  logic       zero = 1'b0;
  logic       pc_write, ir_write, adr_src, mem_write, reg_write, retire, illegal;
  logic [1:0] result_src, alu_srcA, alu_srcB;
  logic [2:0] alu_control, imm_src;

  mc_control_unit dut (
    .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7_5(funct7_5), .zero(zero),
    .pc_write(pc_write), .ir_write(ir_write), .adr_src(adr_src), .mem_write(mem_write),
    .reg_write(reg_write), .result_src(result_src), .alu_srcA(alu_srcA), .alu_srcB(alu_srcB),
    .alu_control(alu_control), .imm_src(imm_src), .retire(retire), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       pc_write;
    logic       ir_write;
    logic       adr_src;
    logic       mem_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] srcA;
    logic [1:0] srcB;
    logic [2:0] alu;
    logic [2:0] imm;
    logic       retire;
    logic       illegal;
  } outs_t;

  int unsigned n_checks = 0;
  int unsigned n_fail = 0;

  logic [6:0]  m_op;
  logic [2:0]  m_f3;
  logic        m_f7, m_zero;
  int unsigned cyc = 0;
  logic        chk_en = 1'b0;
  outs_t       trace [1:5];

  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011,
                         IT = 7'b0010011, BR = 7'b1100011, JL = 7'b1101111,
                         JR = 7'b1100111, LU = 7'b0110111, AU = 7'b0010111;

  function automatic int unsigned ncycles(input logic [6:0] o);
    case (o)
      LW, JR:         return 5;
      SW, RT, IT, JL: return 4;
      BR, LU, AU:     return 3;
      default:        return 2;
    endcase
  endfunction

  function automatic logic [2:0] alu_of(input logic r, input logic [2:0] f3, input logic f7);
    case (f3)
      3'd0:    return (r && f7) ? 3'd1 : 3'd0;
      3'd7:    return 3'd2;
      3'd6:    return 3'd3;
      3'd4:    return 3'd4;
      3'd2:    return 3'd5;
      3'd1:    return 3'd6;
      default: return 3'd7;
    endcase
  endfunction

  // Expected outputs for cycle k (1 = fetch) of an instruction, built from the
  // per-class cycle recipe rather than from any state encoding.
  function automatic outs_t model(input logic [6:0] o, input logic [2:0] f3,
                                  input logic f7, input logic z, input int unsigned k);
    outs_t e;
    int unsigned n;
    e = '0;
    n = ncycles(o);
    case (o)
      LW, JR, IT: e.imm = 3'd0;
      SW:         e.imm = 3'd1;
      BR:         e.imm = 3'd2;
      JL:         e.imm = 3'd3;
      LU, AU:     e.imm = 3'd4;
      default:    e.imm = 3'd0;
    endcase
    e.retire = (k == n);
    if (k == 1) begin
      e.ir_write = 1; e.pc_write = 1; e.srcB = 2; e.result_src = 2;
    end else if (k == 2) begin
      e.srcA = 1; e.srcB = 1; e.illegal = (n == 2);
    end else if (k == n && o != BR && o != LU && o != SW) begin
      e.reg_write = 1;
      e.result_src = (o == LW) ? 2'd1 : 2'd0;
    end else begin
      case (o)
        LW, SW:  if (k == 3) begin e.srcA = 2; e.srcB = 1; end
                 else begin e.adr_src = 1; e.mem_write = (o == SW); end
        RT:      begin e.srcA = 2; e.srcB = 0; e.alu = alu_of(1, f3, f7); end
        IT:      begin e.srcA = 2; e.srcB = 1; e.alu = alu_of(0, f3, f7); end
        BR:      begin e.srcA = 2; e.alu = 3'd1;
                       e.pc_write = (f3 == 0) ? z : (f3 == 1) ? !z : 1'b0; end
        LU:      begin e.result_src = 3; e.reg_write = 1; end
        JL, JR:  if (o == JR && k == 3) begin e.srcA = 2; e.srcB = 1; end
                 else begin e.srcA = 1; e.srcB = 2; e.pc_write = 1; end
        default: ;
      endcase
    end
    return e;
  endfunction

  function automatic outs_t actual();
    outs_t a;
    a.pc_write = pc_write; a.ir_write = ir_write; a.adr_src = adr_src;
    a.mem_write = mem_write; a.reg_write = reg_write; a.result_src = result_src;
    a.srcA = alu_srcA; a.srcB = alu_srcB; a.alu = alu_control; a.imm = imm_src;
    a.retire = retire; a.illegal = illegal;
    return a;
  endfunction

  always @(negedge clk) begin
    #2;
    if (chk_en) begin
      outs_t e, a;
      e = model(m_op, m_f3, m_f7, m_zero, cyc);
      a = actual();
      if (cyc >= 1 && cyc <= 5) trace[cyc] = a;
      n_checks++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL model op=%b f3=%0d cyc=%0d got=%h want=%h", m_op, m_f3, cyc, a, e);
      end
    end
  end

  task automatic lit(input string name, input logic [2:0] got, input logic [2:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  task automatic reset_checks(input string tag);
    lit({tag, "_pc_write"}, {2'b0, pc_write}, 3'd0);
    lit({tag, "_ir_write"}, {2'b0, ir_write}, 3'd0);
    lit({tag, "_mem_write"}, {2'b0, mem_write}, 3'd0);
    lit({tag, "_reg_write"}, {2'b0, reg_write}, 3'd0);
    lit({tag, "_retire"}, {2'b0, retire}, 3'd0);
    lit({tag, "_srcB"}, {1'b0, alu_srcB}, 3'd2);
    lit({tag, "_result_src"}, {1'b0, result_src}, 3'd2);
    lit({tag, "_adr_src"}, {2'b0, adr_src}, 3'd0);
  endtask

  // Called just after a falling edge while the DUT shows FETCH.
  task automatic run(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                     input logic z, input int unsigned abort_at);
    int unsigned n;
    n = ncycles(o);
    m_op = o; m_f3 = f3; m_f7 = f7; m_zero = z;
    op = o; funct3 = f3; funct7_5 = f7; zero = z;
    for (int unsigned k = 1; k <= n; k++) begin
      cyc = k; chk_en = 1'b1;
      #3;
      chk_en = 1'b0;
      if (k == abort_at) begin
        rst = 1'b1;
        #1;
        reset_checks("abort");
        @(negedge clk);
        rst = 1'b0;
        return;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    #1;
    reset_checks("reset");
    @(negedge clk);
    rst = 1'b0;

    run(LW, 3'd2, 0, 0, 0);
    lit("lw_c5_result_src", {1'b0, trace[5].result_src}, 3'd1);
    lit("lw_c5_reg_write", {2'b0, trace[5].reg_write}, 3'd1);
    lit("lw_c4_reg_write", {2'b0, trace[4].reg_write}, 3'd0);
    lit("lw_c5_retire", {2'b0, trace[5].retire}, 3'd1);

    run(SW, 3'd2, 0, 0, 0);
    lit("sw_c4_mem_write", {2'b0, trace[4].mem_write}, 3'd1);
    lit("sw_c4_adr_src", {2'b0, trace[4].adr_src}, 3'd1);
    lit("sw_imm_src", trace[3].imm, 3'd1);

    run(RT, 3'd0, 1, 0, 0);
    lit("sub_alu", trace[3].alu, 3'd1);
    run(RT, 3'd1, 0, 0, 0);
    lit("sll_alu", trace[3].alu, 3'd6);
    run(RT, 3'd0, 0, 0, 0);
    run(IT, 3'd0, 1, 0, 0);
    lit("addi_f7_alu", trace[3].alu, 3'd0);
    run(IT, 3'd4, 0, 0, 0);
    run(RT, 3'd5, 1, 0, 0);

    run(BR, 3'd0, 0, 1, 0);
    lit("beq_z1_pc_write", {2'b0, trace[3].pc_write}, 3'd1);
    run(BR, 3'd0, 0, 0, 0);
    lit("beq_z0_pc_write", {2'b0, trace[3].pc_write}, 3'd0);
    run(BR, 3'd1, 0, 1, 0);
    lit("bne_z1_pc_write", {2'b0, trace[3].pc_write}, 3'd0);
    run(BR, 3'd1, 0, 0, 0);
    lit("bne_z0_pc_write", {2'b0, trace[3].pc_write}, 3'd1);

    run(JL, 3'd0, 0, 0, 0);
    lit("jal_c1_pc_write", {2'b0, trace[1].pc_write}, 3'd1);
    lit("jal_c3_pc_write", {2'b0, trace[3].pc_write}, 3'd1);
    lit("jal_c4_reg_write", {2'b0, trace[4].reg_write}, 3'd1);
    run(JR, 3'd0, 0, 0, 0);
    lit("jalr_c5_retire", {2'b0, trace[5].retire}, 3'd1);
    run(LU, 3'd0, 0, 0, 0);
    lit("lui_c3_result_src", {1'b0, trace[3].result_src}, 3'd3);
    run(AU, 3'd0, 0, 0, 0);
    run(7'b1111111, 3'd0, 0, 0, 0);
    lit("ill_c2_illegal", {2'b0, trace[2].illegal}, 3'd1);
    lit("ill_c2_retire", {2'b0, trace[2].retire}, 3'd1);

    run(LW, 3'd2, 0, 0, 4);
    run(RT, 3'd7, 0, 0, 0);
    lit("post_rst_ir_write", {2'b0, trace[1].ir_write}, 3'd1);
    lit("post_rst_pc_write", {2'b0, trace[1].pc_write}, 3'd1);
    lit("and_alu", trace[3].alu, 3'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mc_control_unit.md
# mc_control_unit

Multicycle sequencer for the RV32I microcontroller datapath. It replaces the single-cycle decoder when the instruction and data memories become one shared memory. A Moore-style FSM steps each instruction through fetch, decode, execute, memory and writeback. It drives the PC/IR write enables, the shared-memory address mux, the ALU operand and operation selects, the result mux and the register-file write. The unit sits beside the datapath in the top level and sees only the instruction fields and the ALU zero flag.

## Interface
- No parameters.
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- op  in  7  Instr[6:0], valid from DECODE onward (IR latched in FETCH)
- funct3  in  3  Instr[14:12]
- funct7_5  in  1  Instr[30]
- zero  in  1  ALU zero flag, combinational from current ALU operands
- pc_write  out  1  PC load enable
- ir_write  out  1  IR and OldPC load enable
- adr_src  out  1  memory address: 0 = PC, 1 = ALUOut
- mem_write  out  1  shared memory / peripheral write enable
- reg_write  out  1  register-file write enable
- result_src  out  2  00 ALUOut, 01 Data reg, 10 ALUResult, 11 ImmExt
- alu_srcA  out  2  00 PC, 01 OldPC, 10 rs1 reg
- alu_srcB  out  2  00 rs2 reg, 01 ImmExt, 10 constant 4
- alu_control  out  3  000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt, 110 sll, 111 srl
- imm_src  out  3  000 I, 001 S, 010 B, 011 J, 100 U
- retire  out  1  high in the last cycle of every instruction, i.e. next state is FETCH
- illegal  out  1  high in DECODE when op is unsupported

## Operation
- Supported ISA: lw, sw, R-ALU, I-ALU, beq, bne, jal, jalr, lui, auipc. Any other op is illegal.
- imm_src is decoded combinationally from op in every state: lw/jalr/I-ALU give I, sw gives S, branch gives B, jal gives J, lui/auipc give U, others give 000.
- Unlisted outputs in each state: write enables 0, selects 00, alu_control add.
- FETCH: adr_src=0, ir_write=1, srcA=00, srcB=10, add, result_src=10, pc_write=1. Next state DECODE.
- DECODE: srcA=01, srcB=01, add, so ALUOut <= OldPC+imm. Next state by op:
  - lw/sw: MEMADR
  - R: EXECR
  - I-ALU: EXECI
  - branch: BRANCH
  - jal: JAL
  - jalr: JALR
  - lui: LUI
  - auipc: ALUWB
  - illegal: FETCH, with illegal=1
- MEMADR: srcA=10, srcB=01, add. Next state MEMREAD for lw, MEMWRITE for sw.
- MEMREAD: adr_src=1. Next state MEMWB.
- MEMWB: result_src=01, reg_write=1. Next state FETCH.
- MEMWRITE: adr_src=1, mem_write=1. Next state FETCH.
- EXECR: srcA=10, srcB=00, alu_control from the ALU decode. Next state ALUWB.
- EXECI: srcA=10, srcB=01, alu_control from the ALU decode. Next state ALUWB.
- ALUWB: result_src=00, reg_write=1. Next state FETCH.
- BRANCH: srcA=10, srcB=00, sub, result_src=00. pc_write = (funct3==000 & zero) | (funct3==001 & ~zero). Next state FETCH.
- JAL: srcA=01, srcB=10, add, result_src=00, pc_write=1. PC takes ALUOut as the target and ALUOut takes OldPC+4. Next state ALUWB.
- JALR: srcA=10, srcB=01, add, so ALUOut <= rs1+imm. Next state JAL.
- LUI: result_src=11, reg_write=1. Next state FETCH.
- ALU decode, for R and I only:
  - funct3 000 gives add, or sub when R & funct7_5
  - 111 gives and, 110 or, 100 xor, 010 slt, 001 sll, 101 srl
  - sra is unsupported and executes as srl

## Timing
- While rst is high: state = FETCH; pc_write, ir_write, mem_write, reg_write, retire and illegal are forced 0; all other outputs hold their FETCH values.
- After reset deassertion, the first rising edge performs FETCH.
- Reset asserted mid-instruction aborts it immediately and no further writes occur.
- Cycles per instruction, including FETCH:
  - lw 5, sw 4, R 4, I 4, jal 4, jalr 5
  - branch 3, lui 3, auipc 3, illegal 2
- Outputs depend only on state and the registered IR fields, except:
  - pc_write in BRANCH, which is combinational on zero
  - illegal, which is combinational on op
- Exactly one retire pulse per instruction. retire and illegal coincide for an illegal op.

## Structure
- Package riscv_mc_pkg holds:
  - the state enum: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, JAL, JALR, LUI
  - opcode constants: 0000011, 0100011, 0110011, 0010011, 1100011, 1101111, 1100111, 0110111, 0010111
  - the alu_control, imm_src, alu_srcA/B and result_src codes
- Sub-module alu_decoder: combinational (is_r, funct3, funct7_5) to alu_control, reused by EXECR and EXECI.

## Test plan
- Reset: assert rst mid-MEMREAD of a lw. Required: all write enables go to 0 immediately; after release, the first cycle shows ir_write=1, pc_write=1.
- lw (op 0000011): required states F, D, MA, MR, WB; reg_write only in cycle 5 with result_src=01; retire in cycle 5.
- sw (op 0100011): required mem_write=1 with adr_src=1 in cycle 4 only; imm_src=001; reg_write never asserted.
- R sub (funct3 000, funct7_5=1), then sll (funct3 001): EXECR alu_control must be 001 for sub and 110 for sll.
- beq with zero=1 gives pc_write=1 in cycle 3; with zero=0 it is 0. bne inverts both.
- jal, jalr, lui and op 1111111:
  - jal: 4 cycles, pc_write in cycles 1 and 3, reg_write in cycle 4
  - jalr: 5 cycles
  - lui: result_src=11 in cycle 3
  - op 1111111: illegal=1 in cycle 2, then FETCH
